// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port, with bounded locked bursts.
// Optional: define REG0_PROTECT_EN to suppress write_enable for writes targeting r0.
module regfile_wr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [NUM_REQ*4-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 write_enable,
    output logic [3:0]           write_reg,
    output logic [7:0]           write_data,
    output logic                 busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [3:0]         lock_cnt, cnt_nxt;
    logic [PW-1:0]      rr_ptr, holder, rr_win, cand, g_idx;
    logic [NUM_REQ-1:0] elig;
    logic               rr_vld, hold_lock, lock_go, g_vld, we_nxt;

    logic [3:0] addr_a [NUM_REQ];
    logic [7:0] data_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[4*i +: 4];
        assign data_a[i] = req_data[8*i +: 8];
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        hold_lock = req[holder] & req_lock[holder];
        // The requester on the output this cycle has stale inputs; skip it.
        elig = req;
        if (state != S_IDLE)
            elig[holder] = 1'b0;

        rr_vld = 1'b0;
        rr_win = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!rr_vld && elig[cand]) begin
                rr_vld = 1'b1;
                rr_win = cand;
            end
        end

        lock_go = hold_lock &&
                  ((state == S_GRANT && MAX_LOCK > 1) ||
                   (state == S_LOCK  && lock_cnt < LOCK_LAST));

        g_vld     = 1'b0;
        g_idx     = '0;
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        if (lock_go) begin
            g_vld     = 1'b1;
            g_idx     = holder;
            state_nxt = S_LOCK;
            cnt_nxt   = (state == S_GRANT) ? 4'd1 : lock_cnt + 4'd1;
        end else if (rr_vld) begin
            g_vld     = 1'b1;
            g_idx     = rr_win;
            state_nxt = S_GRANT;
        end

`ifdef REG0_PROTECT_EN
        we_nxt = g_vld && (addr_a[g_idx] != 4'd0);
`else
        we_nxt = g_vld;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lock_cnt     <= '0;
            rr_ptr       <= '0;
            holder       <= '0;
            gnt          <= '0;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= cnt_nxt;
            gnt          <= g_vld ? (NUM_REQ'(1) << g_idx) : '0;
            write_enable <= we_nxt;
            write_reg    <= g_vld ? addr_a[g_idx] : 4'd0;
            write_data   <= g_vld ? data_a[g_idx] : 8'd0;
            if (g_vld) begin
                holder <= g_idx;
                rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed cases with literal expectations, then
// randomized traffic compared every cycle against a streak/pointer-level model.
module tb_regfile_wr_arbiter;
    localparam int NR = 4;
    localparam int ML = 4;
`ifdef REG0_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req, req_lock, gnt;
    logic [NR*4-1:0] req_addr;
    logic [NR*8-1:0] req_data;
    logic            write_enable, busy;
    logic [3:0]      write_reg;
    logic [7:0]      write_data;

    regfile_wr_arbiter #(.NUM_REQ(NR), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // requester-side stimulus state
    logic [NR-1:0] rq, lk;
    logic [3:0]    a [NR];
    logic [7:0]    d [NR];

    // model: previous grantee, consecutive-grant streak, round-robin start
    int            m_prev, m_streak, m_rr;
    logic [NR-1:0] exp_gnt;
    logic          exp_we, exp_busy;
    logic [3:0]    exp_reg;
    logic [7:0]    exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        req      = rq;
        req_lock = lk;
        for (int i = 0; i < NR; i++) begin
            req_addr[4*i +: 4] = a[i];
            req_data[8*i +: 8] = d[i];
        end
    endtask

    task automatic model_reset();
        m_prev = -1; m_streak = 0; m_rr = 0;
        exp_gnt = '0; exp_we = 0; exp_busy = 0; exp_reg = '0; exp_data = '0;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        if (m_prev >= 0 && rq[m_prev] && lk[m_prev] && m_streak < ML)
            w = m_prev;
        else
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_rr + k) % NR;
                if (w < 0 && rq[idx] && idx != m_prev) w = idx;
            end
        if (w < 0) begin
            m_prev = -1; m_streak = 0;
            exp_gnt = '0; exp_we = 0; exp_busy = 0; exp_reg = '0; exp_data = '0;
        end else begin
            m_streak = (w == m_prev) ? m_streak + 1 : 1;
            m_prev   = w;
            m_rr     = (w + 1) % NR;
            exp_gnt  = '0;
            exp_gnt[w] = 1'b1;
            exp_reg  = a[w];
            exp_data = d[w];
            exp_we   = !(PROT && a[w] == 4'd0);
            exp_busy = 1'b1;
        end
    endtask

    task automatic cmp_all();
        chk("gnt",  32'(gnt), 32'(exp_gnt));
        chk("we",   32'(write_enable), 32'(exp_we));
        chk("reg",  32'(write_reg), 32'(exp_reg));
        chk("data", 32'(write_data), 32'(exp_data));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq = '0; lk = '0;
        for (int i = 0; i < NR; i++) begin a[i] = 4'(i); d[i] = 8'(16*i); end
        drive();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",  32'(gnt), 0);
        chk("rst_we",   32'(write_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        // 3: single write, latency 1
        do_reset();
        chk("rst_reg",  32'(write_reg), 0);
        chk("rst_data", 32'(write_data), 0);
        rq = 4'b0100; a[2] = 4'd5; d[2] = 8'hA5; drive();
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        chk("t3_we", 32'(write_enable), 1);
        chk("t3_reg", 32'(write_reg), 5);
        chk("t3_data", 32'(write_data), 32'hA5);
        chk("t3_model", 32'(exp_gnt), 32'h4);

        // 2: all requesting, rotation
        do_reset();
        rq = 4'b1111; drive();
        for (int c = 0; c < 5; c++) begin
            logic [3:0] seq [5];
            seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            tick();
            chk("t2_gnt", 32'(gnt), 32'(seq[c]));
            chk("t2_model", 32'(exp_gnt), 32'(seq[c]));
        end

        // 4: locked burst of MAX_LOCK, then the waiter
        do_reset();
        rq = 4'b1001; lk = 4'b0001; drive();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_gnt", 32'(gnt), (c < 4) ? 32'h1 : 32'h8);
            chk("t4_model", 32'(exp_gnt), (c < 4) ? 32'h1 : 32'h8);
        end

        // 5: lone requester, every other cycle
        do_reset();
        rq = 4'b0010; drive();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t5_gnt", 32'(gnt), (c % 2 == 0) ? 32'h2 : 32'h0);
        end

        // 6: write to r0
        do_reset();
        rq = 4'b0001; a[0] = 4'd0; d[0] = 8'h77; drive();
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        chk("t6_we", 32'(write_enable), PROT ? 0 : 1);

        // 1: async reset mid-burst
        do_reset();
        rq = 4'b0001; lk = 4'b0001; drive();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_gnt", 32'(gnt), 0);
        chk("t1_we", 32'(write_enable), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_data", 32'(write_data), 0);
        model_reset();
        rq = 4'b0010; lk = '0; drive();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t1_after", 32'(gnt), 32'h2);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (exp_gnt[i] || !rq[i]) begin
                    rq[i] = ($urandom_range(0, 99) < (exp_gnt[i] ? 60 : 35));
                    if (rq[i]) begin
                        a[i] = 4'($urandom_range(0, 15));
                        d[i] = 8'($urandom);
                    end
                    lk[i] = ($urandom_range(0, 99) < (lk[i] ? 85 : 25));
                end
            end
            drive();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
